// File: rtl/tex_vram_arb_if.sv
// Bus bundle for the texture VRAM arbiter: codebook fill port, texel read port and VRAM read port.
// The slave modport is the arbiter's view. The master modport is the view of the clients and the VRAM.
interface tex_vram_arb_if;
    logic        cb_req;
    logic [20:0] cb_base_addr;
    logic [8:0]  cb_len;
    logic        cb_busy;
    logic        cb_wr;
    logic [7:0]  cb_wr_idx;
    logic [63:0] cb_data;

    logic        tx_req;
    logic [20:0] tx_addr;
    logic        tx_ack;
    logic        tx_valid;
    logic [63:0] tx_data;

    logic        vram_rd;
    logic [20:0] vram_word_addr;
    logic        vram_wait;
    logic        vram_valid;
    logic [63:0] vram_din;

    logic        timeout_err;

    modport slave (
        input  cb_req, cb_base_addr, cb_len, tx_req, tx_addr,
               vram_wait, vram_valid, vram_din,
        output cb_busy, cb_wr, cb_wr_idx, cb_data, tx_ack, tx_valid, tx_data,
               vram_rd, vram_word_addr, timeout_err
    );

    modport master (
        output cb_req, cb_base_addr, cb_len, tx_req, tx_addr,
               vram_wait, vram_valid, vram_din,
        input  cb_busy, cb_wr, cb_wr_idx, cb_data, tx_ack, tx_valid, tx_data,
               vram_rd, vram_word_addr, timeout_err
    );
endinterface

// File: rtl/tex_vram_arb.sv
// Shares one VRAM read port between codebook fill bursts and single texel word reads.
// At most one VRAM read is outstanding at a time.
//
// state    | meaning
// IDLE     | arbitrate between cb (request or pending) and tx
// CB_ISSUE | vram_rd held at base+index until accepted
// CB_WAIT  | waiting for the burst word, timer running
// TX_ISSUE | vram_rd held at latched texel address until accepted
// TX_WAIT  | waiting for the texel word, timer running
module tex_vram_arb #(
    parameter int TIMEOUT = 1023
) (
    input  logic          clock,
    input  logic          reset,
    tex_vram_arb_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {IDLE, CB_ISSUE, CB_WAIT, TX_ISSUE, TX_WAIT} state_t;

    state_t        state;
    logic          last_cb;
    logic          cb_pend;
    logic [20:0]   pend_base;
    logic [8:0]    pend_len;
    logic [20:0]   cb_base;
    logic [8:0]    cb_left;
    logic [7:0]    cb_idx;
    logic [TW-1:0] wait_cnt;

    logic [8:0]  req_len;
    logic        cb_win;
    logic [20:0] grant_base;
    logic [8:0]  grant_len;
    logic [7:0]  idx_next;

    assign req_len    = (bus.cb_len == 9'd0 || bus.cb_len > 9'd256) ? 9'd256 : bus.cb_len;
    // On a tie, tx wins only right after a cb burst, so neither side can starve.
    assign cb_win     = (bus.cb_req || cb_pend) && !(bus.tx_req && last_cb);
    assign grant_base = bus.cb_req ? bus.cb_base_addr : pend_base;
    assign grant_len  = bus.cb_req ? req_len : pend_len;
    assign idx_next   = cb_idx + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            last_cb            <= 1'b0;
            cb_pend            <= 1'b0;
            pend_base          <= '0;
            pend_len           <= '0;
            cb_base            <= '0;
            cb_left            <= '0;
            cb_idx             <= '0;
            wait_cnt           <= '0;
            bus.cb_busy        <= 1'b0;
            bus.cb_wr          <= 1'b0;
            bus.cb_wr_idx      <= '0;
            bus.cb_data        <= '0;
            bus.tx_ack         <= 1'b0;
            bus.tx_valid       <= 1'b0;
            bus.tx_data        <= '0;
            bus.vram_rd        <= 1'b0;
            bus.vram_word_addr <= '0;
            bus.timeout_err    <= 1'b0;
        end else begin
            bus.cb_wr    <= 1'b0;
            bus.tx_ack   <= 1'b0;
            bus.tx_valid <= 1'b0;

            // Capture cb_req whenever no burst is active; a grant below clears it again.
            if (bus.cb_req && !bus.cb_busy) begin
                cb_pend   <= 1'b1;
                pend_base <= bus.cb_base_addr;
                pend_len  <= req_len;
            end

            case (state)
                IDLE: begin
                    if (cb_win) begin
                        cb_pend            <= 1'b0;
                        last_cb            <= 1'b1;
                        bus.cb_busy        <= 1'b1;
                        cb_base            <= grant_base;
                        cb_left            <= grant_len;
                        cb_idx             <= 8'd0;
                        bus.vram_rd        <= 1'b1;
                        bus.vram_word_addr <= grant_base;
                        state              <= CB_ISSUE;
                    end else if (bus.tx_req) begin
                        last_cb            <= 1'b0;
                        bus.tx_ack         <= 1'b1;
                        bus.vram_rd        <= 1'b1;
                        bus.vram_word_addr <= bus.tx_addr;
                        state              <= TX_ISSUE;
                    end
                end
                CB_ISSUE, TX_ISSUE: begin
                    if (!bus.vram_wait) begin
                        bus.vram_rd <= 1'b0;
                        wait_cnt    <= TMO_LOAD;
                        state       <= (state == CB_ISSUE) ? CB_WAIT : TX_WAIT;
                    end
                end
                CB_WAIT: begin
                    if (bus.vram_valid) begin
                        bus.cb_wr     <= 1'b1;
                        bus.cb_data   <= bus.vram_din;
                        bus.cb_wr_idx <= cb_idx;
                        cb_idx        <= idx_next;
                        cb_left       <= cb_left - 9'd1;
                        if (cb_left == 9'd1) begin
                            bus.cb_busy <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            bus.vram_rd        <= 1'b1;
                            bus.vram_word_addr <= cb_base + {13'd0, idx_next};
                            state              <= CB_ISSUE;
                        end
                    end else if (wait_cnt == TMO_ONE) begin
                        bus.timeout_err <= 1'b1;
                        bus.cb_busy     <= 1'b0;
                        cb_pend         <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - TMO_ONE;
                    end
                end
                TX_WAIT: begin
                    if (bus.vram_valid) begin
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= bus.vram_din;
                        state        <= IDLE;
                    end else if (wait_cnt == TMO_ONE) begin
                        bus.timeout_err <= 1'b1;
                        bus.tx_valid    <= 1'b1;
                        bus.tx_data     <= '0;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - TMO_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tex_vram_arb.sv
// Self-checking bench for tex_vram_arb: a VRAM responder model, scoreboard queues for the
// expected VRAM addresses, codebook writes and texel data, plus a burst table and corner sequences.
module tb_tex_vram_arb;
    localparam int TMO = 30;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tex_vram_arb_if bus();

    tex_vram_arb #(.TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  idx;
        logic [63:0] data;
    } cb_exp_t;

    cb_exp_t     cb_q[$];
    logic [63:0] tx_q[$];
    logic [20:0] addr_q[$];

    int cyc       = 0;
    int wr_count  = 0;
    int valid_cyc = -10;
    bit tx_tmo_exp = 1'b0;

    int          lat        = 1;
    int          stall_left = 0;
    bit          mute       = 1'b0;
    int          resp_cnt   = 0;
    logic [20:0] resp_addr  = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [20:0] a);
        return {11'h5A5, a, 11'h3C3, ~a};
    endfunction

    task automatic push_burst(input logic [20:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            cb_q.push_back('{idx: 8'(i), data: data_of(base + 21'(i))});
            addr_q.push_back(base + 21'(i));
        end
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_cb_busy"}, 64'(bus.cb_busy), 0);
        check({p, "_cb_wr"}, 64'(bus.cb_wr), 0);
        check({p, "_cb_wr_idx"}, 64'(bus.cb_wr_idx), 0);
        check({p, "_cb_data"}, bus.cb_data, 0);
        check({p, "_tx_ack"}, 64'(bus.tx_ack), 0);
        check({p, "_tx_valid"}, 64'(bus.tx_valid), 0);
        check({p, "_tx_data"}, bus.tx_data, 0);
        check({p, "_vram_rd"}, 64'(bus.vram_rd), 0);
        check({p, "_vram_addr"}, 64'(bus.vram_word_addr), 0);
        check({p, "_timeout_err"}, 64'(bus.timeout_err), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.cb_req = 1'b0;
        bus.tx_req = 1'b0;
        cb_q.delete();
        tx_q.delete();
        addr_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_busy_low(input string name, input int limit);
        int k = 0;
        while (bus.cb_busy !== 1'b0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        if (k >= limit) check(name, 64'(bus.cb_busy), 0);
    endtask

    task automatic wait_sig(input string name, input int which, input int limit);
        int k = 0;
        while (((which == 0) ? bus.tx_ack : bus.tx_valid) !== 1'b1 && k < limit) begin
            @(negedge clock);
            k++;
        end
        check(name, 64'((which == 0) ? bus.tx_ack : bus.tx_valid), 1);
    endtask

    // VRAM responder: stalls the first stall_left read cycles, answers lat cycles after acceptance.
    initial begin
        bus.vram_wait  = 1'b0;
        bus.vram_valid = 1'b0;
        bus.vram_din   = '0;
        forever begin
            @(negedge clock);
            bus.vram_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus.vram_valid = 1'b1;
                    bus.vram_din   = data_of(resp_addr);
                    valid_cyc      = cyc;
                end
            end
            bus.vram_wait = 1'b0;
            if (bus.vram_rd === 1'b1) begin
                if (addr_q.size() > 0) check("vram_addr", 64'(bus.vram_word_addr), 64'(addr_q[0]));
                else check("vram_rd_unexpected", 64'(bus.vram_rd), 0);
                if (stall_left > 0) begin
                    stall_left--;
                    bus.vram_wait = 1'b1;
                end else begin
                    if (addr_q.size() > 0) void'(addr_q.pop_front());
                    if (!mute) begin
                        resp_cnt  = lat;
                        resp_addr = bus.vram_word_addr;
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every cb_wr and tx_valid strobe.
    initial begin
        cb_exp_t     e;
        logic [63:0] d;
        forever begin
            @(negedge clock);
            if (bus.cb_wr === 1'b1) begin
                wr_count++;
                if (cb_q.size() == 0) check("cb_wr_unexpected", 64'(bus.cb_wr), 0);
                else begin
                    e = cb_q.pop_front();
                    check("cb_wr_idx", 64'(bus.cb_wr_idx), 64'(e.idx));
                    check("cb_data", bus.cb_data, e.data);
                    check("cb_busy_at_wr", 64'(bus.cb_busy), 64'(cb_q.size() != 0));
                end
            end
            if (bus.tx_valid === 1'b1) begin
                if (tx_q.size() == 0) check("tx_valid_unexpected", 64'(bus.tx_valid), 0);
                else begin
                    d = tx_q.pop_front();
                    check("tx_data", bus.tx_data, d);
                    if (!tx_tmo_exp) check("tx_valid_latency", 64'(cyc), 64'(valid_cyc + 1));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required below 1000000", $time);
        $fatal(1);
    end

    typedef struct {
        logic [20:0] base;
        logic [8:0]  len;
        int          lat;
        int          stall;
        int          exp_n;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   start;
        int   k;

        vecs[0] = '{base: 21'h001000, len: 9'd4,   lat: 1, stall: 0, exp_n: 4};
        vecs[1] = '{base: 21'h0ABCDE, len: 9'd300, lat: 2, stall: 3, exp_n: 256};
        vecs[2] = '{base: 21'h1FFFFE, len: 9'd0,   lat: 1, stall: 0, exp_n: 256};
        vecs[3] = '{base: 21'h000123, len: 9'd1,   lat: 3, stall: 0, exp_n: 1};
        vecs[4] = '{base: 21'h100000, len: 9'd256, lat: 1, stall: 5, exp_n: 256};

        bus.cb_req       = 1'b0;
        bus.cb_base_addr = '0;
        bus.cb_len       = '0;
        bus.tx_req       = 1'b0;
        bus.tx_addr      = '0;

        do_reset();
        check_all_zero("reset");

        // Burst table: length clamping, zero length, address wrap, VRAM stalls.
        for (int v = 0; v < 5; v++) begin
            @(negedge clock);
            lat        = vecs[v].lat;
            stall_left = vecs[v].stall;
            push_burst(vecs[v].base, vecs[v].exp_n);
            start            = wr_count;
            bus.cb_req       = 1'b1;
            bus.cb_base_addr = vecs[v].base;
            bus.cb_len       = vecs[v].len;
            @(negedge clock);
            bus.cb_req = 1'b0;
            check($sformatf("vec%0d_busy_rise", v), 64'(bus.cb_busy), 1);
            wait_busy_low($sformatf("vec%0d_busy_fall_bound", v), 3000);
            @(negedge clock);
            check($sformatf("vec%0d_words", v), 64'(wr_count - start), 64'(vecs[v].exp_n));
            check($sformatf("vec%0d_cb_q_empty", v), 64'(cb_q.size()), 0);
        end
        check("cb_data_hold", bus.cb_data, data_of(21'h100000 + 21'd255));

        // Simultaneous requests after reset: the burst goes first.
        do_reset();
        @(negedge clock);
        lat = 1;
        push_burst(21'h001000, 4);
        addr_q.push_back(21'h1FFFFF);
        tx_q.push_back(data_of(21'h1FFFFF));
        start            = wr_count;
        bus.cb_req       = 1'b1;
        bus.cb_base_addr = 21'h001000;
        bus.cb_len       = 9'd4;
        bus.tx_req       = 1'b1;
        bus.tx_addr      = 21'h1FFFFF;
        @(negedge clock);
        bus.cb_req = 1'b0;
        check("sim_cb_first", 64'(bus.cb_busy), 1);
        check("sim_no_tx_ack", 64'(bus.tx_ack), 0);
        wait_sig("sim_tx_ack", 0, 200);
        bus.tx_req = 1'b0;
        check("sim_burst_before_tx", 64'(wr_count - start), 4);
        check("sim_tx_vram_rd", 64'(bus.vram_rd), 1);
        check("sim_tx_vram_addr", 64'(bus.vram_word_addr), 64'h1FFFFF);
        wait_sig("sim_tx_valid", 1, 50);
        repeat (3) @(negedge clock);
        check("tx_data_hold", bus.tx_data, data_of(21'h1FFFFF));
        check("sim_tx_q_empty", 64'(tx_q.size()), 0);

        // A burst completes, then a new cb_req ties with a held tx_req: tx is served first.
        @(negedge clock);
        push_burst(21'h002000, 3);
        bus.cb_req       = 1'b1;
        bus.cb_base_addr = 21'h002000;
        bus.cb_len       = 9'd3;
        @(negedge clock);
        bus.cb_req = 1'b0;
        wait_busy_low("b2b_first_bound", 200);
        @(negedge clock);
        addr_q.push_back(21'h0F0F0F);
        tx_q.push_back(data_of(21'h0F0F0F));
        push_burst(21'h003000, 2);
        start            = wr_count;
        bus.cb_req       = 1'b1;
        bus.cb_base_addr = 21'h003000;
        bus.cb_len       = 9'd2;
        bus.tx_req       = 1'b1;
        bus.tx_addr      = 21'h0F0F0F;
        @(negedge clock);
        bus.cb_req = 1'b0;
        check("b2b_tx_ack_latency", 64'(bus.tx_ack), 1);
        check("b2b_tx_vram_rd", 64'(bus.vram_rd), 1);
        check("b2b_cb_waits", 64'(bus.cb_busy), 0);
        bus.tx_req = 1'b0;
        k = 0;
        while (bus.cb_busy !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("b2b_pending_granted", 64'(bus.cb_busy), 1);
        check("b2b_tx_done_first", 64'(tx_q.size()), 0);
        wait_busy_low("b2b_second_bound", 200);
        @(negedge clock);
        check("b2b_second_words", 64'(wr_count - start), 2);

        // Stall for 10 cycles, then no response at all: timeout.
        @(negedge clock);
        mute       = 1'b1;
        stall_left = 10;
        tx_tmo_exp = 1'b1;
        addr_q.push_back(21'h0ABCDE);
        tx_q.push_back(64'd0);
        bus.tx_req  = 1'b1;
        bus.tx_addr = 21'h0ABCDE;
        @(negedge clock);
        check("tmo_tx_ack", 64'(bus.tx_ack), 1);
        bus.tx_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_vram_rd", 64'(bus.vram_rd), 1);
            check("stall_vram_addr", 64'(bus.vram_word_addr), 64'h0ABCDE);
            @(negedge clock);
        end
        repeat (5) @(negedge clock);
        check("tmo_not_early", 64'(bus.timeout_err), 0);
        wait_sig("tmo_tx_valid", 1, TMO + 20);
        @(negedge clock);
        check("tmo_err_set", 64'(bus.timeout_err), 1);
        check("tmo_tx_q_empty", 64'(tx_q.size()), 0);
        repeat (5) @(negedge clock);
        check("tmo_err_sticky", 64'(bus.timeout_err), 1);
        mute       = 1'b0;
        tx_tmo_exp = 1'b0;
        do_reset();
        check("tmo_err_cleared", 64'(bus.timeout_err), 0);

        // Reset while waiting for word 100 of a 256-word burst; the late vram_valid must be ignored.
        @(negedge clock);
        lat = 6;
        push_burst(21'h040000, 256);
        start            = wr_count;
        bus.cb_req       = 1'b1;
        bus.cb_base_addr = 21'h040000;
        bus.cb_len       = 9'd0;
        @(negedge clock);
        bus.cb_req = 1'b0;
        k = 0;
        while ((wr_count - start) < 100 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check("mid_reached_100", 64'(wr_count - start), 100);
        @(negedge clock);
        check("mid_in_wait_busy", 64'(bus.cb_busy), 1);
        check("mid_in_wait_rd", 64'(bus.vram_rd), 0);
        reset = 1'b1;
        cb_q.delete();
        addr_q.delete();
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("late_valid_no_wr", 64'(wr_count - start), 100);
        check("late_valid_idle", 64'(bus.cb_busy), 0);

        check("end_cb_q_empty", 64'(cb_q.size()), 0);
        check("end_tx_q_empty", 64'(tx_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tex_vram_arb.md
TEX_VRAM_ARB -- requirements
Module: tex_vram_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for vram_valid after a read is accepted.
REQ-002 SHALL have port clock, input, 1 bit: the only clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cb_req, input, 1 bit: pulse to start a codebook fill burst.
REQ-005 SHALL have port cb_base_addr, input, 21 bits: 64-bit word address of the codebook, sampled on the accepted cb_req.
REQ-006 SHALL have port cb_len, input, 9 bits: burst length in words; 0 means 256; values above 256 are clamped to 256.
REQ-007 SHALL have port cb_busy, output, 1 bit: high while a burst is active.
REQ-008 SHALL have port cb_wr, output, 1 bit: one-cycle strobe that writes one codebook word.
REQ-009 SHALL have port cb_wr_idx, output, 8 bits: codebook index for the word written on cb_wr.
REQ-010 SHALL have port cb_data, output, 64 bits: codebook word written on cb_wr.
REQ-011 SHALL have port tx_req, input, 1 bit: texel word read request; held until tx_ack.
REQ-012 SHALL have port tx_addr, input, 21 bits: texel word address; stable while tx_req is high.
REQ-013 SHALL have port tx_ack, output, 1 bit: one-cycle pulse when the texel request is accepted.
REQ-014 SHALL have port tx_valid, output, 1 bit: one-cycle pulse when tx_data is valid.
REQ-015 SHALL have port tx_data, output, 64 bits: texel read data.
REQ-016 SHALL have port vram_rd, output, 1 bit: VRAM read strobe.
REQ-017 SHALL have port vram_word_addr, output, 21 bits: VRAM 64-bit word address.
REQ-018 SHALL have port vram_wait, input, 1 bit: VRAM busy; a read is accepted on a rising edge where vram_rd=1 and vram_wait=0.
REQ-019 SHALL have port vram_valid, input, 1 bit: read data valid on vram_din.
REQ-020 SHALL have port vram_din, input, 64 bits: VRAM read data.
REQ-021 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-022 SHALL use the states IDLE, CB_ISSUE, CB_WAIT, TX_ISSUE and TX_WAIT, with at most one VRAM read outstanding.
REQ-023 SHALL arbitrate in IDLE as follows: if cb_req and tx_req are simultaneous, cb wins unless the last completed grant was a cb burst, in which case tx wins; cb_req that loses arbitration is latched as pending.
REQ-024 SHALL, on a cb grant, set cb_busy=1, latch the base address and the effective length, clear the index to 0, and enter CB_ISSUE on the next cycle.
REQ-025 SHALL, in CB_ISSUE, hold vram_rd=1 with vram_word_addr = base + index (mod 2^21) until accepted, then go to CB_WAIT.
REQ-026 SHALL, in CB_WAIT on vram_valid, next cycle drive cb_wr=1, cb_data=vram_din and cb_wr_idx=index, then increment the index.
REQ-027 SHALL, after the last word is written, go to CB_ISSUE if words remain, otherwise drop cb_busy and go to IDLE in the same cycle as the final cb_wr.
REQ-028 SHALL not interrupt a cb burst; tx_req waits, and cb_req while cb_busy=1 is ignored.
REQ-029 SHALL, on a tx grant, pulse tx_ack, latch tx_addr and enter TX_ISSUE; vram_rd is high in the cycle after the grant (tx_req to vram_rd latency 1 cycle).
REQ-030 SHALL, in TX_ISSUE, hold vram_rd=1 with the latched address until accepted, then go to TX_WAIT.
REQ-031 SHALL, in TX_WAIT on vram_valid, next cycle pulse tx_valid with tx_data=vram_din and go to IDLE.
REQ-032 SHALL ignore vram_valid in IDLE and ISSUE states.
REQ-033 SHALL keep vram_rd=0 outside ISSUE states.
REQ-034 SHALL count cycles in a WAIT state; if the count reaches TIMEOUT, it SHALL set timeout_err=1 (sticky until reset) and go to IDLE.
REQ-035 SHALL, on a cb timeout, drop cb_busy without cb_wr and discard any pending cb.
REQ-036 SHALL, on a tx timeout, pulse tx_valid with tx_data=0.
REQ-037 SHALL hold tx_data and cb_data at their last value between strobes.

Reset
REQ-038 SHALL, when reset=1 at a rising edge, regardless of state including mid-burst, go to IDLE, clear the pending cb and last-grant flag (next tie goes to cb), and set all outputs to 0: cb_busy, cb_wr, cb_wr_idx, cb_data, tx_ack, tx_valid, tx_data, vram_rd, vram_word_addr and timeout_err.
REQ-039 SHALL ignore any vram_valid belonging to a read accepted before reset.

Verification
REQ-040 SHALL cover a burst of 4: cb_req with cb_base_addr=0x001000 and cb_len=4, zero wait -> vram_word_addr 0x001000..0x001003 and cb_wr_idx 0..3 with matching data, then cb_busy=0.
REQ-041 SHALL cover a simultaneous request: cb_req and tx_req (tx_addr=0x1FFFFF) in the same cycle -> full burst first, then tx_ack, vram_rd at 0x1FFFFF, and tx_valid 1 cycle after vram_valid.
REQ-042 SHALL cover back-to-back bursts with tx pending: after a burst ends, a new cb_req and a held tx_req -> tx is served before the second burst.
REQ-043 SHALL cover address wrap: cb_base_addr=0x1FFFFE with cb_len=0 -> 256 writes, addresses wrapping to 0x000000 after 0x1FFFFF.
REQ-044 SHALL cover stall and timeout: vram_wait=1 for 10 cycles -> vram_rd and vram_word_addr stable; then no vram_valid for TIMEOUT cycles -> timeout_err=1 and tx_valid with tx_data=0.
REQ-045 SHALL cover reset during CB_WAIT at index 100 -> all outputs 0 the next cycle, and a late vram_valid produces no cb_wr.
